sample_pacer: RTL and testbench
===============================

SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 SHALL have parameter WIDTH_D, default 18, sample data width in bits (two's complement).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth in samples; power of two, >= 2.
REQ-003 SHALL have parameter MIN_GAP, default 6, minimum clk cycles between successive outStrobe pulses; range 1..255.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge; reset rst, synchronous, active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port inValid  input  1  dataIn holds a sample this cycle.
REQ-007 SHALL have port inReady  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port dataIn  input  WIDTH_D  signed input sample.
REQ-009 SHALL have port outStrobe  output  1  one-cycle pulse marking new dataOut; drives a downstream biquad inStrobe.
REQ-010 SHALL have port dataOut  output  WIDTH_D  signed paced sample; registered.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy, registered.

Function
REQ-012 SHALL accept a write on any cycle where inValid && inReady; the sample is stored at wrPtr, wrPtr increments modulo DEPTH.
REQ-013 SHALL drive inReady = (level != DEPTH), from registered occupancy only; a read in the same cycle does not raise inReady.
REQ-014 SHALL run a two-state pacer FSM: ST_READY (gap expired) and ST_GAP (counting).
REQ-015 In ST_READY with level != 0, SHALL pop one sample: dataOut <= fifo[rdPtr], outStrobe <= 1 next cycle, rdPtr increments modulo DEPTH, gap counter loads MIN_GAP-1.
REQ-016 After a pop, FSM SHALL enter ST_GAP if MIN_GAP > 1, else stay ST_READY.
REQ-017 In ST_GAP, counter SHALL decrement once per cycle; at counter == 1 (i.e. on the decrement to 0) FSM SHALL return to ST_READY.
REQ-018 Consecutive outStrobe pulses SHALL be exactly MIN_GAP cycles apart while FIFO is non-empty, never closer.
REQ-019 outStrobe SHALL be high for exactly one cycle per popped sample; low otherwise.
REQ-020 dataOut SHALL hold its value between strobes.
REQ-021 Latency: sample written at edge N into empty FIFO with FSM in ST_READY SHALL appear with outStrobe high in the cycle after edge N+1 (empty-check uses registered level).
REQ-022 Simultaneous write and pop SHALL leave level unchanged; write-only +1; pop-only -1.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 without loss or reordering; output order equals input order.
REQ-024 When empty, ST_READY SHALL idle with no strobe; counter state is irrelevant.

Reset
REQ-025 On rst: level=0, wrPtr=0, rdPtr=0, FSM=ST_READY, counter=0, outStrobe=0, dataOut=0, inReady=1 (following cycle).
REQ-026 rst mid-operation SHALL discard all buffered samples and any pending gap; a write presented during rst SHALL be ignored.
REQ-027 Initial values SHALL match reset values.

Configuration
REQ-028 Macro SAMPLE_PACER_OVERFLOW_EN: when defined, SHALL add output port overflow (1 bit), sticky, set the cycle after inValid && !inReady, cleared only by rst (reset value 0).
REQ-029 Without SAMPLE_PACER_OVERFLOW_EN, port overflow SHALL not exist; rejected writes are silently ignored; all other behaviour identical.

Verification
REQ-030 Single sample: rst, then inValid=1 one cycle with dataIn=0x00123 -> outStrobe single pulse 2 cycles after write edge, dataOut=0x00123, level back to 0.
REQ-031 Burst: 8 back-to-back samples 1..8, MIN_GAP=6 -> 8 strobes spaced exactly 6 cycles, dataOut 1..8 in order, inReady stays 1.
REQ-032 Full: DEPTH=8, 12 back-to-back inValid -> inReady falls when level=8, accepted samples output in order, no corruption; with SAMPLE_PACER_OVERFLOW_EN overflow=1 and sticky until rst.
REQ-033 Wrap: 20 samples at one per 6 cycles with MIN_GAP=6 -> level never exceeds 2, 20 strobes, values match across pointer wrap.
REQ-034 Reset mid-burst: 5 samples queued, rst asserted after second strobe -> no further strobes, level=0, dataOut=0, overflow=0; next sample -> normal single-sample latency.
REQ-035 MIN_GAP=1: 4 back-to-back samples -> 4 strobes on consecutive cycles, values in order.

Source files
------------

// File: rtl/sample_pacer.sv
// sample_pacer: small sample FIFO that releases samples as one-cycle strobes
//    spaced at least MIN_GAP clk cycles apart, for feeding a biquad.
// Latency: a sample written into an empty, idle pacer strobes out 2 edges later.
// Backpressure: inReady drops while the FIFO holds DEPTH samples; a pop in the
//    same cycle does not reopen it until the registered level drops.
//
// Ports:
//    clk, rst      rising-edge clock, synchronous active-high reset
//    inValid/inReady/dataIn   sample input handshake (two's complement data)
//    outStrobe     one-cycle pulse when dataOut carries a new sample
//    dataOut       registered paced sample, held between strobes
//    level         registered FIFO occupancy
//    overflow      (only with SAMPLE_PACER_OVERFLOW_EN) sticky flag set the
//                  cycle after a write is offered while full; cleared by rst
//
// Optional feature macro: SAMPLE_PACER_OVERFLOW_EN
// Register start-up state is established by asserting rst.

module sample_pacer #(
   parameter int WIDTH_D = 18,
   parameter int DEPTH   = 8,
   parameter int MIN_GAP = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      inValid,
   output logic                      inReady,
   input  logic signed [WIDTH_D-1:0] dataIn,
   output logic                      outStrobe,
   output logic signed [WIDTH_D-1:0] dataOut,
   output logic [$clog2(DEPTH):0]    level
`ifdef SAMPLE_PACER_OVERFLOW_EN
   ,
   output logic                      overflow
`endif
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]     LVL_ZERO = '0;
   localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [7:0]      GAP_LOAD = 8'(MIN_GAP - 1);

   typedef enum logic {
      ST_READY = 1'b0,
      ST_GAP   = 1'b1
   } state_t;

   logic signed [WIDTH_D-1:0] mem_q [DEPTH];
   logic signed [WIDTH_D-1:0] mem_d [DEPTH];

   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [AW:0]               level_q, level_d;
   state_t                    state_q, state_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      strobe_q, strobe_d;
   logic signed [WIDTH_D-1:0] data_out_q, data_out_d;
`ifdef SAMPLE_PACER_OVERFLOW_EN
   logic                      overflow_q, overflow_d;
`endif

   logic                      wr_en;
   logic                      pop_en;

   // Ready looks only at the registered level, so a full FIFO stays closed for
   // the cycle in which it pops.
   assign inReady   = (level_q != LVL_FULL);
   assign outStrobe = strobe_q;
   assign dataOut   = data_out_q;
   assign level     = level_q;
`ifdef SAMPLE_PACER_OVERFLOW_EN
   assign overflow  = overflow_q;
`endif

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      strobe_d   = 1'b0;
`ifdef SAMPLE_PACER_OVERFLOW_EN
      overflow_d = overflow_q | (inValid & ~inReady);
`endif

      wr_en  = inValid && inReady;
      // Empty check uses the registered level: a sample written this edge can
      // only be popped on the following edge.
      pop_en = (state_q == ST_READY) && (level_q != LVL_ZERO);

      if (wr_en) begin
         mem_d[wr_ptr_q] = dataIn;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      if (pop_en) begin
         data_out_d = mem_q[rd_ptr_q];
         strobe_d   = 1'b1;
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         cnt_d      = GAP_LOAD;
         // With MIN_GAP == 1 there is nothing to wait for, so pop every cycle.
         state_d    = (MIN_GAP > 1) ? ST_GAP : ST_READY;
      end else if (state_q == ST_GAP) begin
         cnt_d = cnt_q - 8'd1;
         // Leaving on the 1 -> 0 step makes the next pop land exactly MIN_GAP
         // edges after the previous one.
         if (cnt_q <= 8'd1) begin
            state_d = ST_READY;
         end
      end

      unique case ({wr_en, pop_en})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= ST_READY;
         cnt_q      <= '0;
         strobe_q   <= 1'b0;
         data_out_q <= '0;
`ifdef SAMPLE_PACER_OVERFLOW_EN
         overflow_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         strobe_q   <= strobe_d;
         data_out_q <= data_out_d;
`ifdef SAMPLE_PACER_OVERFLOW_EN
         overflow_q <= overflow_d;
`endif
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_sample_pacer.sv
// tb_sample_pacer: drives two pacers (MIN_GAP 6 and 1) with the same input
//    stream and compares every cycle against a queue-and-timestamp model,
//    plus directed checks of strobe spacing, ordering, reset and latency.

module tb_sample_pacer;

   localparam int W = 18;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] data_in = '0;

   logic         rdy6, stb6, rdy1, stb1;
   logic [W-1:0] dout6, dout1;
   logic [3:0]   lvl6, lvl1;
`ifdef SAMPLE_PACER_OVERFLOW_EN
   logic         ovf6, ovf1;
`endif

   always #5 clk = ~clk;

   sample_pacer #(.WIDTH_D(W), .DEPTH(D), .MIN_GAP(6)) u_g6 (
      .clk(clk), .rst(rst), .inValid(in_valid), .inReady(rdy6), .dataIn(data_in),
      .outStrobe(stb6), .dataOut(dout6), .level(lvl6)
`ifdef SAMPLE_PACER_OVERFLOW_EN
      , .overflow(ovf6)
`endif
   );

   sample_pacer #(.WIDTH_D(W), .DEPTH(D), .MIN_GAP(1)) u_g1 (
      .clk(clk), .rst(rst), .inValid(in_valid), .inReady(rdy1), .dataIn(data_in),
      .outStrobe(stb1), .dataOut(dout1), .level(lvl1)
`ifdef SAMPLE_PACER_OVERFLOW_EN
      , .overflow(ovf1)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: pending samples in a circular list, a pop happens on an
   // edge when something was pending before that edge and at least MIN_GAP
   // edges have passed since the previous pop.
   int           gap_of [2];
   int           m_cnt  [2];
   int           m_head [2];
   int           m_last [2];
   logic [W-1:0] m_buf  [2][16];
   logic [W-1:0] m_dout [2];
   logic         m_stb  [2];
   logic         m_ovf  [2];

   int           st6[$], st1[$];
   logic [W-1:0] sv6[$], sv1[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_edge(input int i);
      bit ready;
      bit pop;
      if (rst) begin
         m_cnt[i] = 0; m_head[i] = 0; m_last[i] = -1000;
         m_dout[i] = '0; m_stb[i] = 1'b0; m_ovf[i] = 1'b0;
         return;
      end
      ready = (m_cnt[i] != D);
      pop   = (m_cnt[i] != 0) && (cyc >= m_last[i] + gap_of[i]);
      m_stb[i] = pop;
      if (pop) begin
         m_dout[i] = m_buf[i][m_head[i]];
         m_head[i] = (m_head[i] + 1) % 16;
         m_cnt[i]--;
         m_last[i] = cyc;
      end
      if (in_valid) begin
         if (ready) begin
            m_buf[i][(m_head[i] + m_cnt[i]) % 16] = data_in;
            m_cnt[i]++;
         end else begin
            m_ovf[i] = 1'b1;
         end
      end
   endtask

   task automatic cmp_inst(input string nm, input int i, input logic stb,
                           input logic [W-1:0] dout, input logic [3:0] lvl, input logic rdy);
      check_val({nm, ".strobe"}, stb, m_stb[i]);
      check_val({nm, ".data"}, dout, m_dout[i]);
      check_val({nm, ".level"}, lvl, m_cnt[i]);
      check_val({nm, ".ready"}, rdy, (m_cnt[i] != D));
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) model_edge(i);
      @(posedge clk);
      #1;
      cyc++;
      cmp_inst("g6", 0, stb6, dout6, lvl6, rdy6);
      cmp_inst("g1", 1, stb1, dout1, lvl1, rdy1);
`ifdef SAMPLE_PACER_OVERFLOW_EN
      check_val("g6.ovf", ovf6, m_ovf[0]);
      check_val("g1.ovf", ovf1, m_ovf[1]);
`endif
      if (stb6 === 1'b1) begin st6.push_back(cyc); sv6.push_back(dout6); end
      if (stb1 === 1'b1) begin st1.push_back(cyc); sv1.push_back(dout1); end
   endtask

   task automatic push(input logic [W-1:0] v);
      in_valid = 1'b1;
      data_in  = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_log();
      st6.delete(); sv6.delete(); st1.delete(); sv1.delete();
   endtask

   initial begin
      int max_lvl;
      int seen;
      int nstb;
      gap_of[0] = 6;
      gap_of[1] = 1;

      // Reset state
      rst = 1'b1;
      idle(3);
      check_val("rst.level", lvl6, 0);
      check_val("rst.ready", rdy6, 1);
      check_val("rst.dout", dout6, 0);
      check_val("rst.strobe", stb6, 0);
      rst = 1'b0;

      // Single sample: strobe on the second edge after the write
      clear_log();
      push(18'h00123);
      check_val("single.early", stb6, 0);
      step();
      check_val("single.strobe", stb6, 1);
      check_val("single.data", dout6, 18'h00123);
      check_val("single.level", lvl6, 0);
      idle(10);
      check_val("single.count", st6.size(), 1);

      // Burst 1..8: spacing 6 (g6) and 1 (g1), in order
      clear_log();
      for (int k = 1; k <= 8; k++) push(W'(k));
      idle(60);
      check_val("burst.g6.count", st6.size(), 8);
      check_val("burst.g1.count", st1.size(), 8);
      for (int k = 0; k < 8 && k < st6.size() && k < st1.size(); k++) begin
         check_val($sformatf("burst.g6.val%0d", k), sv6[k], k + 1);
         check_val($sformatf("burst.g1.val%0d", k), sv1[k], k + 1);
         if (k > 0) begin
            check_val($sformatf("burst.g6.gap%0d", k), st6[k] - st6[k-1], 6);
            check_val($sformatf("burst.g1.gap%0d", k), st1[k] - st1[k-1], 1);
         end
      end

      // Full: 12 back-to-back offers, g6 fills and must reject some
      clear_log();
      for (int k = 0; k < 12; k++) push(W'($urandom));
      check_val("full.g6.reached", (st6.size() < 12), 1);
      idle(90);
`ifdef SAMPLE_PACER_OVERFLOW_EN
      check_val("full.g6.ovf", ovf6, 1);
      idle(5);
      check_val("full.g6.ovf_sticky", ovf6, 1);
`endif

      // Wrap: 20 samples one per 6 cycles, level stays low
      clear_log();
      max_lvl = 0;
      for (int k = 0; k < 20; k++) begin
         push(W'(18'h20000 + k));
         if (lvl6 > max_lvl) max_lvl = lvl6;
         for (int j = 0; j < 5; j++) begin
            step();
            if (lvl6 > max_lvl) max_lvl = lvl6;
         end
      end
      idle(20);
      check_val("wrap.maxlvl", (max_lvl <= 2), 1);
      check_val("wrap.count", st6.size(), 20);
      for (int k = 0; k < 20 && k < sv6.size(); k++)
         check_val($sformatf("wrap.val%0d", k), sv6[k], 18'h20000 + k);

      // Reset mid-burst after the second strobe
      clear_log();
      for (int k = 0; k < 5; k++) push(W'(18'h00100 + k));
      seen = 0;
      for (int t = 0; t < 100 && st6.size() < 2; t++) step();
      seen = st6.size();
      check_val("midrst.wait", seen, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      nstb = st6.size();
      idle(30);
      check_val("midrst.nostrobe", st6.size(), nstb);
      check_val("midrst.level", lvl6, 0);
      check_val("midrst.dout", dout6, 0);
`ifdef SAMPLE_PACER_OVERFLOW_EN
      check_val("midrst.ovf", ovf6, 0);
`endif
      push(18'h3ABCD);
      check_val("post.early", stb6, 0);
      step();
      check_val("post.strobe", stb6, 1);
      check_val("post.data", dout6, 18'h3ABCD);
      idle(10);

      // Randomized traffic with occasional reset
      for (int blk = 0; blk < 16; blk++) begin
         int p;
         p = $urandom_range(5, 95);
         for (int k = 0; k < 50; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 99) < p);
            data_in  = W'($urandom);
            step();
         end
      end
      rst = 1'b0;
      idle(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
